// File: rtl/pipe_pkg.sv
// Shared definitions for the MEM/WB pipeline register: control-bit indices
// and the default-sized payload layout carried from MEM to WB.
package pipe_pkg;

    localparam int CTRL_REG_WRITE  = 0;
    localparam int CTRL_MEM_TO_REG = 1;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_REG_W  = 3;
    localparam int DEF_CTRL_W = 2;

    // Field order matches the flat vector packed by mem_wb_pipe_reg:
    // {ctrl, read_data, alu_result, rd}, rd in the least significant bits.
    typedef struct packed {
        logic [DEF_CTRL_W-1:0] ctrl;
        logic [DEF_DATA_W-1:0] read_data;
        logic [DEF_DATA_W-1:0] alu_result;
        logic [DEF_REG_W-1:0]  rd;
    } mem_wb_payload_t;

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic two-entry valid/ready skid buffer with flush. The main entry drives
// the output; the skid entry catches the one extra word that can arrive while
// the output is stalled, which lets in_ready be a plain flop.
module pipe_skid_buf
    import pipe_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic         main_valid_r;
    logic         skid_valid_r;
    logic         in_ready_r;
    logic [W-1:0] main_data_r;
    logic [W-1:0] skid_data_r;

    logic         accept_s;
    logic         drain_s;
    logic         main_valid_nx_s;
    logic         skid_valid_nx_s;
    logic         main_we_s;
    logic         main_from_skid_s;
    logic         skid_we_s;

    // Next-state and write-enable decode for the two entries.
    always_comb begin
        accept_s         = in_valid & in_ready_r;
        drain_s          = main_valid_r & out_ready;
        main_valid_nx_s  = main_valid_r;
        skid_valid_nx_s  = skid_valid_r;
        main_we_s        = 1'b0;
        main_from_skid_s = 1'b0;
        skid_we_s        = 1'b0;
        if (flush) begin
            // Squash everything, including any word offered this cycle.
            main_valid_nx_s = 1'b0;
            skid_valid_nx_s = 1'b0;
        end else if (!main_valid_r) begin
            if (accept_s) begin
                main_we_s       = 1'b1;
                main_valid_nx_s = 1'b1;
            end else begin
                main_valid_nx_s = 1'b0;
            end
        end else if (drain_s) begin
            if (skid_valid_r) begin
                // in_ready was low, so no accept can collide with this move.
                main_we_s        = 1'b1;
                main_from_skid_s = 1'b1;
                skid_valid_nx_s  = 1'b0;
            end else if (accept_s) begin
                main_we_s = 1'b1;
            end else begin
                main_valid_nx_s = 1'b0;
            end
        end else begin
            if (accept_s) begin
                skid_we_s       = 1'b1;
                skid_valid_nx_s = 1'b1;
            end else begin
                skid_we_s = 1'b0;
            end
        end
    end

    // Entry state, payload and registered in_ready with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            main_valid_r <= 1'b0;
            skid_valid_r <= 1'b0;
            in_ready_r   <= 1'b0;
            main_data_r  <= {W{1'b0}};
            skid_data_r  <= {W{1'b0}};
        end else begin
            main_valid_r <= main_valid_nx_s;
            skid_valid_r <= skid_valid_nx_s;
            in_ready_r   <= ~skid_valid_nx_s;
            if (main_we_s) begin
                main_data_r <= main_from_skid_s ? skid_data_r : in_data;
            end
            if (skid_we_s) begin
                skid_data_r <= in_data;
            end
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = main_valid_r;
    assign out_data  = main_data_r;

endmodule

// File: rtl/mem_wb_pipe_reg.sv
// MEM/WB pipeline stage register: a skid buffer holding the MEM payload, plus
// the write-back select mux, register-file write enable and the forwarding
// view of the head entry for the EX bypass.
module mem_wb_pipe_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int REG_W       = 3,
    parameter int CTRL_W      = 2,
    parameter int ZERO_REG_RO = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_read_data,
    input  logic [DATA_W-1:0] in_alu_result,
    input  logic [REG_W-1:0]  in_rd,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_read_data,
    output logic [DATA_W-1:0] out_alu_result,
    output logic [REG_W-1:0]  out_rd,
    output logic              wb_we,
    output logic [DATA_W-1:0] wb_data,
    output logic              fwd_valid,
    output logic [REG_W-1:0]  fwd_rd,
    output logic [DATA_W-1:0] fwd_data
);

    localparam int PAY_W = CTRL_W + 2 * DATA_W + REG_W;
    localparam int ALU_LO = REG_W;
    localparam int RDD_LO = REG_W + DATA_W;
    localparam int CTL_LO = REG_W + 2 * DATA_W;

    logic [PAY_W-1:0] in_pay_s;
    logic [PAY_W-1:0] out_pay_s;
    logic             rd_ok_s;
    logic             reg_write_s;

    assign in_pay_s = {in_ctrl, in_read_data, in_alu_result, in_rd};

    pipe_skid_buf #(
        .W (PAY_W)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_pay_s),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_pay_s)
    );

    assign out_rd         = out_pay_s[ALU_LO-1:0];
    assign out_alu_result = out_pay_s[RDD_LO-1:ALU_LO];
    assign out_read_data  = out_pay_s[CTL_LO-1:RDD_LO];
    assign out_ctrl       = out_pay_s[PAY_W-1:CTL_LO];

    // Write-back select and the register-zero write suppression.
    always_comb begin
        reg_write_s = out_ctrl[CTRL_REG_WRITE];
        if (out_ctrl[CTRL_MEM_TO_REG]) begin
            wb_data = out_read_data;
        end else begin
            wb_data = out_alu_result;
        end
        if (ZERO_REG_RO != 32'sd0) begin
            rd_ok_s = (out_rd != {REG_W{1'b0}});
        end else begin
            rd_ok_s = 1'b1;
        end
    end

    // A flush squashes the head, so it must not reach the register file.
    assign wb_we     = out_valid & out_ready & reg_write_s & rd_ok_s & ~flush;
    assign fwd_valid = out_valid & reg_write_s & rd_ok_s;
    assign fwd_rd    = out_rd;
    assign fwd_data  = wb_data;

endmodule
